// File: rtl/tpu_pkg.sv
// Shared definitions for the tpuv1 control path: host address map and
// the compute sequencer state encoding.
package tpu_pkg;

  localparam int unsigned A_BASE   = 'h100;
  localparam int unsigned B_BASE   = 'h200;
  localparam int unsigned C_BASE   = 'h300;
  localparam int unsigned CMD_ADDR = 'h400;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} seq_state_t;

endpackage

// File: rtl/tpu_addr_dec.sv
// Combinational host address decode: region hits plus the row/half fields
// carried in the address. Gating by write strobe and busy is done by the caller.
module tpu_addr_dec
  import tpu_pkg::*;
#(
  parameter int DIM   = 8,
  parameter int ADDRW = 16
) (
  input  logic [ADDRW-1:0]        addr,
  output logic                    hit_a,
  output logic                    hit_b,
  output logic                    hit_c,
  output logic                    hit_cmd,
  output logic [$clog2(DIM)-1:0]  ab_row,
  output logic [$clog2(DIM)-1:0]  c_row,
  output logic                    c_half
);

  localparam int RW = $clog2(DIM);

  // A/B rows are 8 bytes apart; C half-rows are 8 bytes, so full C rows are 16.
  assign hit_a   = (addr >= ADDRW'(A_BASE)) && (addr < ADDRW'(A_BASE + 8 * DIM));
  assign hit_b   = (addr >= ADDRW'(B_BASE)) && (addr < ADDRW'(B_BASE + 8 * DIM));
  assign hit_c   = (addr >= ADDRW'(C_BASE)) && (addr < ADDRW'(C_BASE + 16 * DIM));
  assign hit_cmd = (addr == ADDRW'(CMD_ADDR));

  assign ab_row = addr[3 +: RW];
  assign c_row  = addr[4 +: RW];
  assign c_half = addr[3];

endmodule

// File: rtl/tpu_seq_ctrl.sv
// Host write decode and compute sequencer for the DIM x DIM systolic array:
// operand fetch (FILL), zero-fed drain (DRAIN), completion pulse (DONE).
module tpu_seq_ctrl
  import tpu_pkg::*;
#(
  parameter int DIM   = 8,
  parameter int ADDRW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDRW-1:0]        addr,
  input  logic                    r_w,
  output logic                    a_wr_en,
  output logic                    b_wr_en,
  output logic                    c_wr_en,
  output logic [$clog2(DIM)-1:0]  wr_row,
  output logic                    c_half,
  output logic                    mem_rd_en,
  output logic [$clog2(DIM)-1:0]  mem_rd_row,
  output logic                    sa_en,
  output logic                    sa_zero,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int RW = $clog2(DIM);
  localparam int CW = $clog2(3 * DIM);

  seq_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sa_en_q, sa_en_d;
  logic            sa_zero_q, sa_zero_d;
  logic            overrun_q, overrun_d;

  logic            hit_a, hit_b, hit_c, hit_cmd, c_half_raw;
  logic [RW-1:0]   ab_row, c_row;
  logic            wr_ok, cmd_acc, wr_drop;

  tpu_addr_dec #(.DIM(DIM), .ADDRW(ADDRW)) u_addr_dec (
    .addr    (addr),
    .hit_a   (hit_a),
    .hit_b   (hit_b),
    .hit_c   (hit_c),
    .hit_cmd (hit_cmd),
    .ab_row  (ab_row),
    .c_row   (c_row),
    .c_half  (c_half_raw)
  );

  assign busy    = (state_q != IDLE);
  assign wr_ok   = r_w && !busy;
  assign cmd_acc = wr_ok && hit_cmd;
  assign wr_drop = r_w && busy && (hit_a || hit_b || hit_c || hit_cmd);

  assign a_wr_en = wr_ok && hit_a;
  assign b_wr_en = wr_ok && hit_b;
  assign c_wr_en = wr_ok && hit_c;
  assign c_half  = c_wr_en && c_half_raw;
  assign wr_row  = (a_wr_en || b_wr_en) ? ab_row : (c_wr_en ? c_row : '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_rd_en  = 1'b0;
    mem_rd_row = '0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_acc) begin
          state_d = FILL;
          cnt_d   = '0;
        end
      end
      FILL: begin
        mem_rd_en  = 1'b1;
        mem_rd_row = cnt_q[RW-1:0];
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(DIM - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        // Last partial sums leave the array 2*DIM-1 cycles after the final fetch.
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(3 * DIM - 2)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // One-cycle delay lines up array enable with operand-buffer read data.
  assign sa_en_d   = (state_q == FILL) || (state_q == DRAIN);
  assign sa_zero_d = (state_q == DRAIN);

  always_comb begin
    overrun_d = overrun_q;
    if (wr_drop)      overrun_d = 1'b1;
    else if (cmd_acc) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sa_en_q   <= 1'b0;
      sa_zero_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sa_en_q   <= sa_en_d;
      sa_zero_q <= sa_zero_d;
      overrun_q <= overrun_d;
    end
  end

  assign sa_en   = sa_en_q;
  assign sa_zero = sa_zero_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Scoreboard bench for tpu_seq_ctrl: a cycle-age reference model predicts every
// output; a negedge monitor pops predictions and compares against the DUT.
module tb_tpu_seq_ctrl;

  localparam int DIM   = 8;
  localparam int ADDRW = 16;
  localparam int TOT   = 3 * DIM;

  logic             clk;
  logic             rst;
  logic [ADDRW-1:0] addr;
  logic             r_w;
  logic             a_wr_en, b_wr_en, c_wr_en, c_half;
  logic [2:0]       wr_row, mem_rd_row;
  logic             mem_rd_en, sa_en, sa_zero, busy, done, overrun;

  tpu_seq_ctrl #(.DIM(DIM), .ADDRW(ADDRW)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .r_w        (r_w),
    .a_wr_en    (a_wr_en),
    .b_wr_en    (b_wr_en),
    .c_wr_en    (c_wr_en),
    .wr_row     (wr_row),
    .c_half     (c_half),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_row (mem_rd_row),
    .sa_en      (sa_en),
    .sa_zero    (sa_zero),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int  cyc;
    bit  a, b, c, half, rd_en, sa_en, sa_zero, busy, done, ovr;
    int  row, rd_row;
    bit  chk_row, chk_rd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;
  // Model: age = cycles since the accepted command (1..3*DIM while busy, else 0).
  int   age    = 0;
  bit   m_ovr  = 1'b0;
  bit   post_rst = 1'b1;

  task automatic chk(input string name, input int c, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, c, act, req);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("a_wr_en",   e.cyc, int'(a_wr_en),   int'(e.a));
      chk("b_wr_en",   e.cyc, int'(b_wr_en),   int'(e.b));
      chk("c_wr_en",   e.cyc, int'(c_wr_en),   int'(e.c));
      chk("mem_rd_en", e.cyc, int'(mem_rd_en), int'(e.rd_en));
      chk("sa_en",     e.cyc, int'(sa_en),     int'(e.sa_en));
      chk("sa_zero",   e.cyc, int'(sa_zero),   int'(e.sa_zero));
      chk("busy",      e.cyc, int'(busy),      int'(e.busy));
      chk("done",      e.cyc, int'(done),      int'(e.done));
      chk("overrun",   e.cyc, int'(overrun),   int'(e.ovr));
      if (e.chk_row) begin
        chk("wr_row", e.cyc, int'(wr_row), e.row);
        chk("c_half", e.cyc, int'(c_half), int'(e.half));
      end
      if (e.chk_rd) chk("mem_rd_row", e.cyc, int'(mem_rd_row), e.rd_row);
    end
  end

  // Drives one cycle of host activity, predicts that cycle's outputs, then
  // advances the reference model by the edge that ends the cycle.
  task automatic drive(input bit t_rst, input bit t_rw, input int t_addr);
    exp_t e;
    bit bsy, ina, inb, inc, iscmd;
    @(posedge clk);
    #1;
    cyc++;
    rst  = t_rst;
    r_w  = t_rw;
    addr = t_addr[15:0];
    bsy   = (age >= 1) && (age <= TOT);
    ina   = (t_addr >= 'h100) && (t_addr < 'h100 + 8 * DIM);
    inb   = (t_addr >= 'h200) && (t_addr < 'h200 + 8 * DIM);
    inc   = (t_addr >= 'h300) && (t_addr < 'h300 + 16 * DIM);
    iscmd = (t_addr == 'h400);
    e.cyc     = cyc;
    e.a       = t_rw && !bsy && ina;
    e.b       = t_rw && !bsy && inb;
    e.c       = t_rw && !bsy && inc;
    e.row     = e.a ? (t_addr - 'h100) / 8 :
                e.b ? (t_addr - 'h200) / 8 :
                e.c ? (t_addr - 'h300) / 16 : 0;
    e.half    = e.c && (((t_addr / 8) % 2) == 1);
    e.rd_en   = (age >= 1) && (age <= DIM);
    e.rd_row  = e.rd_en ? age - 1 : 0;
    e.sa_en   = (age >= 2) && (age <= TOT);
    e.sa_zero = (age >= DIM + 2) && (age <= TOT);
    e.busy    = bsy;
    e.done    = (age == TOT);
    e.ovr     = m_ovr;
    e.chk_row = e.a || e.b || e.c || (post_rst && !t_rw);
    e.chk_rd  = e.rd_en || post_rst;
    q.push_back(e);
    if (t_rw || t_rst)
      $display("txn cyc=%0d rst=%0d w=%0d addr=0x%03h busy=%0d", cyc, t_rst, t_rw, t_addr, bsy);
    if (t_rst) begin
      age   = 0;
      m_ovr = 1'b0;
    end else begin
      if (t_rw && bsy && (ina || inb || inc || iscmd)) m_ovr = 1'b1;
      else if (t_rw && !bsy && iscmd)                 m_ovr = 1'b0;
      if (!bsy) age = (t_rw && iscmd) ? 1 : 0;
      else      age = (age == TOT) ? 0 : age + 1;
    end
    post_rst = t_rst;
  endtask

  task automatic idle_until_age(input int target);
    int n;
    n = 0;
    while (age != target && n < 100) begin
      drive(1'b0, 1'b0, 0);
      n++;
    end
    if (age != target) begin
      checks++;
      $display("FAIL wait_age cyc=%0d actual=%0d required=%0d", cyc, age, target);
    end
  endtask

  initial begin
    rst  = 1'b1;
    r_w  = 1'b0;
    addr = '0;
    drive(1'b1, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
    drive(1'b0, 1'b0, 0);

    // Directed decode writes.
    drive(1'b0, 1'b1, 'h108);
    drive(1'b0, 1'b1, 'h238);
    drive(1'b0, 1'b1, 'h358);
    drive(1'b0, 1'b1, 'h380);
    drive(1'b0, 1'b1, 'h13F);
    drive(1'b0, 1'b1, 'h140);
    drive(1'b0, 1'b0, 0);

    // Full sequence, write while busy at T5, command in DONE, command at T25.
    drive(1'b0, 1'b1, 'h400);
    for (int i = 1; i < 5; i++) drive(1'b0, 1'b0, 0);
    drive(1'b0, 1'b1, 'h100);
    idle_until_age(TOT);
    drive(1'b0, 1'b1, 'h400);
    drive(1'b0, 1'b1, 'h400);

    // Reset for two cycles mid-FILL; done must never follow.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
    drive(1'b1, 1'b0, 0);
    for (int i = 0; i < TOT + 4; i++) drive(1'b0, 1'b0, 0);

    // Command coincident with reset is ignored.
    drive(1'b1, 1'b1, 'h400);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0);

    // Randomized host traffic.
    for (int i = 0; i < 3000; i++) begin
      int sel, a;
      bit rr, ww;
      rr  = ($urandom_range(0, 199) == 0);
      ww  = ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 5);
      case (sel)
        0:       a = 'h100 + $urandom_range(0, 8 * DIM + 15);
        1:       a = 'h200 + $urandom_range(0, 8 * DIM + 15);
        2:       a = 'h300 + $urandom_range(0, 16 * DIM + 15);
        3, 5:    a = 'h400;
        default: a = $urandom_range(0, 'hFFFF);
      endcase
      drive(rr, ww, a);
    end
    drive(1'b0, 1'b0, 0);

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain cyc=%0d actual=%0d required=0", cyc, q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
